sd_read_arbiter: RTL and testbench
==================================

// Module: sd_read_arbiter
// PURPOSE
//  Shares one SD block-read controller among NUM_CH sample-fetch drivers (one per voice/sample stream).
//  Each channel presents the same start/available/valid/data handshake a driver expects from the SD controller.
//  Pending requests are latched and served one 512-byte read at a time, round-robin.
//  Returned bytes are routed only to the granted channel. Sits between the drivers and the SD controller.
// PARAMETERS
//  NUM_CH       4   number of requesting channels (2..8)
//  ACK_TIMEOUT  16  cycles to wait for sd_available to fall after sd_start before re-issuing
// PORTS
//  clk            in   1          system clock
//  rst            in   1          synchronous, active-high reset
//  req_start      in   NUM_CH     per-channel 1-cycle read request pulse
//  req_address    in   NUM_CH*32  per-channel byte address; ch i = [32*i+31:32*i]; sampled with req_start
//  req_available  out  NUM_CH     channel may issue req_start (registered)
//  req_valid      out  NUM_CH     byte strobe, one-hot to granted channel (registered)
//  req_data       out  8          read byte, shared by all channels (registered)
//  sd_start       out  1          1-cycle start pulse to SD controller
//  sd_address     out  32         address of granted request; held stable from ISSUE until RELEASE
//  sd_available   in   1          SD controller idle/ready
//  sd_valid       in   1          SD controller byte strobe
//  sd_data        in   8          SD controller byte
//  grant_id       out  3          index of the channel currently being served
//  busy           out  1          1 in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0, except req_available = all 1s. pending = 0; rr_ptr = 0; state = IDLE.
//   Reset mid-transfer discards all pending requests and in-flight data; the SD controller is not notified.
//  Request capture:
//   - req_start[i] with req_available[i] = 1: set pending[i] and latch the address. req_available[i] drops the next cycle.
//   - req_start[i] with req_available[i] = 0: ignored.
//   - Simultaneous starts on several channels are all captured.
//  req_available[i] = ~pending[i]. It rises the cycle after RELEASE for the served channel.
//  FSM:
//   IDLE    : if any pending and sd_available = 1, grant the first pending channel at or after rr_ptr
//             (modulo NUM_CH). Load grant_id and sd_address, then go to ISSUE.
//   ISSUE   : sd_start = 1 for exactly this cycle. Clear the timeout counter, then go to ACK.
//   ACK     : sd_available = 0 -> XFER.
//             Counter reaches ACK_TIMEOUT-1 with sd_available still 1 -> ISSUE (re-issue the same request).
//   XFER    : each sd_valid registers req_data <= sd_data and req_valid[grant_id] <= 1 (1-cycle latency).
//             sd_available = 1 -> RELEASE.
//   RELEASE : clear pending[grant_id]; rr_ptr <= grant_id+1 mod NUM_CH; go to IDLE.
//             No new grant is made in this cycle (one dead cycle between reads).
//  sd_valid outside XFER is dropped; req_valid stays 0.
//  Channels with no pending request never see req_valid.
//  Worst-case wait for a channel: NUM_CH-1 full reads ahead of it.
// CONFIGURATION
//  SD_ARB_STATS_EN defined: adds ports xfer_cnt (out, 32) and drop_cnt (out, 16), both reset to 0.
//   - xfer_cnt increments once per RELEASE and wraps at 2^32.
//   - drop_cnt increments per cycle in which at least one req_start is ignored; it saturates at 16'hFFFF.
//  SD_ARB_STATS_EN undefined: no counters and no extra ports; behaviour is otherwise identical.
// TESTING
//  1. Reset, then pulse req_start[2] with addr 0x00000400 -> sd_start 2 cycles later, sd_address = 0x400, grant_id = 2,
//     req_available = 4'b1011 until 1 cycle after RELEASE.
//  2. Pulse req_start[0], [1] and [3] in the same cycle -> served in order 0,1,3; starting from rr_ptr = 2 instead,
//     the order is 3,0,1.
//  3. XFER with 512 sd_valid bytes 0..255,0..255 on channel 1 -> req_valid[1] pulses 512 times, each 1 cycle after sd_valid;
//     req_data matches; other req_valid bits stay 0.
//  4. Hold sd_available = 1 after sd_start for 16 cycles -> second sd_start pulse at the same sd_address;
//     sd_available falls on the 5th cycle after it -> XFER.
//  5. req_start[1] while pending[1] = 1 -> ignored, address unchanged; with SD_ARB_STATS_EN defined, drop_cnt = 1.
//  6. Assert rst during XFER -> next cycle busy = 0, sd_start = 0, req_available = all 1s, and later sd_valid produces
//     no req_valid.

Source files
------------

// File: rtl/sd_read_arbiter.sv
// sd_read_arbiter: round-robin sharing of one SD block-read controller among NUM_CH fetch drivers
// Optional statistics counters (xfer_cnt, drop_cnt) are built when SD_ARB_STATS_EN is defined.
module sd_read_arbiter #(
   parameter int NUM_CH      = 4,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_CH-1:0]    req_start,
   input  logic [NUM_CH*32-1:0] req_address,
   output logic [NUM_CH-1:0]    req_available,
   output logic [NUM_CH-1:0]    req_valid,
   output logic [7:0]           req_data,
   output logic                 sd_start,
   output logic [31:0]          sd_address,
   input  logic                 sd_available,
   input  logic                 sd_valid,
   input  logic [7:0]           sd_data,
   output logic [2:0]           grant_id,
   output logic                 busy
`ifdef SD_ARB_STATS_EN
   ,
   output logic [31:0]          xfer_cnt,
   output logic [15:0]          drop_cnt
`endif
);
   localparam int CW = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, ISSUE, ACK, XFER, RELEASE} state_t;

   state_t            state, state_nxt;
   logic [NUM_CH-1:0] pending, cap, clr, gnt_oh;
   logic [31:0]       addr_q [NUM_CH];
   logic [31:0]       addr_nxt;
   logic [2:0]        rr_ptr, gnt_nxt;
   logic              gnt_ok;
   logic [CW-1:0]     cnt;
   int                j;

   assign cap           = req_start & ~pending;
   assign gnt_oh        = NUM_CH'(1) << grant_id;
   assign clr           = (state == RELEASE) ? gnt_oh : '0;
   assign req_available = ~pending;
   assign sd_start      = state == ISSUE;
   assign busy          = state != IDLE;

   // first pending channel at or after rr_ptr, wrapping modulo NUM_CH
   always_comb begin
      gnt_ok  = 1'b0;
      gnt_nxt = '0;
      j       = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NUM_CH) j = j - NUM_CH;
         if (!gnt_ok && |(pending & (NUM_CH'(1) << j))) begin
            gnt_ok  = 1'b1;
            gnt_nxt = 3'(j);
         end
      end
   end

   // address of the channel about to be granted
   always_comb begin
      addr_nxt = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (gnt_nxt == 3'(i)) addr_nxt = addr_q[i];
   end

   // latch a request; a channel can only re-request after its read is released
   always_ff @(posedge clk) begin
      if (rst) pending <= '0;
      else     pending <= (pending | cap) & ~clr;
   end

   // per-channel address captured together with an accepted req_start
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++)
         if (rst)         addr_q[i] <= '0;
         else if (cap[i]) addr_q[i] <= req_address[32*i +: 32];
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next state: grant, pulse start, wait for acceptance (with re-issue), stream, release
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = (gnt_ok && sd_available) ? ISSUE : IDLE;
         ISSUE:   state_nxt = ACK;
         ACK:     state_nxt = !sd_available ? XFER : (cnt == CW'(ACK_TIMEOUT - 1)) ? ISSUE : ACK;
         XFER:    state_nxt = sd_available ? RELEASE : XFER;
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // grant bookkeeping, acknowledge timeout and byte routing to the granted channel
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_id   <= '0;
         sd_address <= '0;
         rr_ptr     <= '0;
         cnt        <= '0;
         req_valid  <= '0;
         req_data   <= '0;
      end else begin
         if (state == IDLE && state_nxt == ISSUE) begin
            grant_id   <= gnt_nxt;
            sd_address <= addr_nxt;
         end
         cnt       <= (state == ISSUE) ? '0 : (state == ACK) ? cnt + CW'(1) : cnt;
         req_valid <= (state == XFER && sd_valid) ? gnt_oh : '0;
         if (state == XFER && sd_valid) req_data <= sd_data;
         if (state == RELEASE) rr_ptr <= (grant_id == 3'(NUM_CH - 1)) ? 3'd0 : grant_id + 3'd1;
      end
   end

`ifdef SD_ARB_STATS_EN
   logic [NUM_CH-1:0] ign;

   assign ign = req_start & pending;

   // completed-read counter (wrapping) and ignored-request cycle counter (saturating)
   always_ff @(posedge clk) begin
      if (rst) begin
         xfer_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         if (state == RELEASE) xfer_cnt <= xfer_cnt + 32'd1;
         if (|ign && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_sd_read_arbiter.sv
// tb_sd_read_arbiter: directed scoreboard bench for sd_read_arbiter
module tb_sd_read_arbiter;
   localparam int NUM_CH = 4;
   localparam int ACK_TIMEOUT = 16;

   logic               clk = 0;
   logic               rst;
   logic [NUM_CH-1:0]  req_start;
   logic [NUM_CH*32-1:0] req_address;
   logic [NUM_CH-1:0]  req_available, req_valid;
   logic [7:0]         req_data;
   logic               sd_start;
   logic [31:0]        sd_address;
   logic               sd_available, sd_valid;
   logic [7:0]         sd_data;
   logic [2:0]         grant_id;
   logic               busy;
`ifdef SD_ARB_STATS_EN
   logic [31:0]        xfer_cnt;
   logic [15:0]        drop_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic [11:0] q[$];
   logic [11:0] e;

   sd_read_arbiter #(.NUM_CH(NUM_CH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req_start(req_start), .req_address(req_address),
      .req_available(req_available), .req_valid(req_valid), .req_data(req_data),
      .sd_start(sd_start), .sd_address(sd_address), .sd_available(sd_available),
      .sd_valid(sd_valid), .sd_data(sd_data), .grant_id(grant_id), .busy(busy)
`ifdef SD_ARB_STATS_EN
      , .xfer_cnt(xfer_cnt), .drop_cnt(drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // every driven byte must come out on the granted channel exactly one cycle later
   always @(posedge clk) begin
      #2;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("req_valid", 32'(req_valid), 32'(NUM_CH'(1) << e[11:8]));
         chk("req_data", 32'(req_data), 32'(e[7:0]));
      end else
         chk("req_valid_idle", 32'(req_valid), 32'd0);
   end

   task automatic request(input logic [NUM_CH-1:0] m, input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] a2, input logic [31:0] a3);
      req_start = m;
      req_address = {a3, a2, a1, a0};
      tick();
      req_start = '0;
   endtask

   task automatic wait_start(input int ch, input logic [31:0] addr);
      int i;
      for (i = 0; i < 40 && !sd_start; i++) tick();
      chk("sd_start_seen", 32'(sd_start), 32'd1);
      chk("grant_id", 32'(grant_id), 32'(ch));
      chk("sd_address", sd_address, addr);
   endtask

   // called at the negedge where sd_start is visible (or later in ACK with lag > 0)
   task automatic run_xfer(input int ch, input logic [31:0] addr, input int nb, input int base, input int lag);
      sd_valid = 1;
      sd_data = 8'hEE;
      repeat (lag) tick();
      sd_available = 0;
      tick();
      if (lag == 0) tick();
      for (int i = 0; i < nb; i++) begin
         sd_valid = 1;
         sd_data = 8'(base + i);
         q.push_back({4'(ch), sd_data});
         tick();
      end
      sd_valid = 0;
      sd_available = 1;
      tick();
      chk("release_busy", 32'(busy), 32'd1);
      chk("release_addr", sd_address, addr);
      chk("release_avail", 32'(req_available[ch]), 32'd0);
      tick();
      chk("dead_cycle_busy", 32'(busy), 32'd0);
      chk("post_avail", 32'(req_available[ch]), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      int g;
      rst = 1; req_start = '0; req_address = '0;
      sd_available = 1; sd_valid = 0; sd_data = '0;
      repeat (3) tick();
      chk("rst_avail", 32'(req_available), 32'hF);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_start", 32'(sd_start), 32'd0);
      chk("rst_grant", 32'(grant_id), 32'd0);
      chk("rst_addr", sd_address, 32'd0);
      chk("rst_data", 32'(req_data), 32'd0);
      rst = 0;
      tick();

      // single request on channel 2
      request(4'b0100, 0, 0, 32'h400, 0);
      chk("t1_avail", 32'(req_available), 32'hB);
      chk("t1_start_early", 32'(sd_start), 32'd0);
      tick();
      chk("t1_start", 32'(sd_start), 32'd1);
      chk("t1_busy", 32'(busy), 32'd1);
      wait_start(2, 32'h400);
      run_xfer(2, 32'h400, 4, 8'h10, 0);
      chk("t1_avail_all", 32'(req_available), 32'hF);

      // simultaneous requests from rr_ptr = 0
      rst = 1; tick(); rst = 0; tick();
      request(4'b1011, 32'h1000, 32'h2000, 0, 32'h3000);
      chk("t2_avail", 32'(req_available), 32'h4);
      wait_start(0, 32'h1000); run_xfer(0, 32'h1000, 3, 8'h20, 0);
      wait_start(1, 32'h2000); run_xfer(1, 32'h2000, 3, 8'h30, 0);
      wait_start(3, 32'h3000); run_xfer(3, 32'h3000, 3, 8'h40, 0);

      // full 512-byte read on channel 1, leaves rr_ptr = 2
      request(4'b0010, 0, 32'h0ABC_0000, 0, 0);
      wait_start(1, 32'h0ABC_0000);
      run_xfer(1, 32'h0ABC_0000, 512, 0, 0);

      // simultaneous requests from rr_ptr = 2
      request(4'b1011, 32'h1100, 32'h2200, 0, 32'h3300);
      wait_start(3, 32'h3300); run_xfer(3, 32'h3300, 2, 8'h50, 0);
      wait_start(0, 32'h1100); run_xfer(0, 32'h1100, 2, 8'h60, 0);
      wait_start(1, 32'h2200); run_xfer(1, 32'h2200, 2, 8'h70, 0);

      // acknowledge timeout and re-issue
      request(4'b0001, 32'h5555_0000, 0, 0, 0);
      wait_start(0, 32'h5555_0000);
      for (g = 1; g < 40; g++) begin
         tick();
         if (sd_start) break;
      end
      chk("t4_gap", 32'(g), 32'(ACK_TIMEOUT + 1));
      wait_start(0, 32'h5555_0000);
      run_xfer(0, 32'h5555_0000, 4, 8'h80, 5);

      // re-request while pending is ignored
      rst = 1; tick(); rst = 0; tick();
      request(4'b0010, 0, 32'hAAAA_0000, 0, 0);
      wait_start(1, 32'hAAAA_0000);
      request(4'b0010, 0, 32'hBBBB_0000, 0, 0);
      run_xfer(1, 32'hAAAA_0000, 4, 8'h90, 1);
      repeat (5) begin
         tick();
         chk("t5_no_start", 32'(sd_start), 32'd0);
         chk("t5_avail", 32'(req_available), 32'hF);
      end
`ifdef SD_ARB_STATS_EN
      chk("t5_drop_cnt", 32'(drop_cnt), 32'd1);
      chk("t5_xfer_cnt", xfer_cnt, 32'd1);
`endif

      // reset during XFER
      request(4'b0100, 0, 0, 32'hCCCC_0000, 0);
      wait_start(2, 32'hCCCC_0000);
      sd_available = 0;
      tick(); tick();
      for (int i = 0; i < 3; i++) begin
         sd_valid = 1;
         sd_data = 8'(8'hA0 + i);
         q.push_back({4'd2, sd_data});
         tick();
      end
      rst = 1; sd_valid = 0;
      tick();
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_start", 32'(sd_start), 32'd0);
      chk("t6_avail", 32'(req_available), 32'hF);
      rst = 0;
      repeat (5) begin
         sd_valid = 1;
         sd_data = 8'h5A;
         tick();
         chk("t6_idle", 32'(busy), 32'd0);
      end
      sd_valid = 0; sd_available = 1;
      repeat (4) begin
         tick();
         chk("t6_no_start", 32'(sd_start), 32'd0);
      end
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
